// File: rtl/tilemap_pkg.sv
// Shared loader state encoding, reset scroll values and sizing helpers
// for the tilemap scroll generator.
package tilemap_pkg;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_HLO,
    LD_HHI,
    LD_VS,
    LD_WAIT_COMMIT
  } load_state_e;

  localparam logic [15:0] HS_RESET = 16'h001F;
  localparam logic [9:0]  VS_RESET = 10'h00F;

  function automatic int layer_bits(input int layers);
    return (layers >= 4) ? 2 : ((layers >= 2) ? 1 : 0);
  endfunction

  function automatic int va_width(input int layers, input int hs_w, input int vs_w);
    return layer_bits(layers) + (vs_w - 3) + (hs_w - 3);
  endfunction

  function automatic int win_size(input int layers);
    return 8 / layers;
  endfunction

endpackage

// File: rtl/tilemap_scroll_regs.sv
// One layer's scroll state: shadow registers filled byte by byte by the
// loader, and active registers that only change on an atomic commit.
module tilemap_scroll_regs
  import tilemap_pkg::*;
#(
  parameter int HS_W = 9,
  parameter int VS_W = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wr_hlo_i,
  input  logic            wr_hhi_i,
  input  logic            wr_vlo_i,
  input  logic            wr_vhi_i,
  input  logic [7:0]      data_i,
  input  logic            commit_i,
  input  logic            discard_i,
  output logic [HS_W-1:0] hs_o,
  output logic [VS_W-1:0] vs_o
);

  localparam logic [HS_W-1:0] HS_LO_MASK = HS_W'(16'h00FF);
  localparam logic [VS_W-1:0] VS_LO_MASK = VS_W'(16'h00FF);

  logic [HS_W-1:0] hs_sh_q, hs_sh_d, hs_act_q, hs_act_d;
  logic [VS_W-1:0] vs_sh_q, vs_sh_d, vs_act_q, vs_act_d;

  // Byte merges are written as masks so that VS_W == 8 needs no special case.
  always_comb begin
    hs_sh_d  = hs_sh_q;
    vs_sh_d  = vs_sh_q;
    hs_act_d = hs_act_q;
    vs_act_d = vs_act_q;
    if (discard_i) begin
      hs_sh_d = hs_act_q;
      vs_sh_d = vs_act_q;
    end else begin
      if (wr_hlo_i) hs_sh_d = (hs_sh_q & ~HS_LO_MASK) | HS_W'(data_i);
      if (wr_hhi_i) hs_sh_d = (hs_sh_q & HS_LO_MASK) | HS_W'({data_i, 8'h00});
      if (wr_vlo_i) vs_sh_d = (vs_sh_q & ~VS_LO_MASK) | VS_W'(data_i);
      if (wr_vhi_i) vs_sh_d = (vs_sh_q & VS_LO_MASK) | VS_W'({data_i, 8'h00});
    end
    if (commit_i) begin
      hs_act_d = hs_sh_q;
      vs_act_d = vs_sh_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hs_sh_q  <= HS_W'(HS_RESET);
      vs_sh_q  <= VS_W'(VS_RESET);
      hs_act_q <= HS_W'(HS_RESET);
      vs_act_q <= VS_W'(VS_RESET);
    end else begin
      hs_sh_q  <= hs_sh_d;
      vs_sh_q  <= vs_sh_d;
      hs_act_q <= hs_act_d;
      vs_act_q <= vs_act_d;
    end
  end

  assign hs_o = hs_act_q;
  assign vs_o = vs_act_q;

endmodule

// File: rtl/tilemap_scroll_gen.sv
// Tilemap scroll address generator: time-slices the VRAM bus between CPU and
// per-layer tile fetches, and loads per-line scroll values from a byte stream.
module tilemap_scroll_gen
  import tilemap_pkg::*;
#(
  parameter int LAYERS = 2,
  parameter int HS_W   = 9,
  parameter int VS_W   = 8,
  localparam int VA_W  = va_width(LAYERS, HS_W, VS_W),
  localparam int FL_W  = (layer_bits(LAYERS) < 1) ? 1 : layer_bits(LAYERS)
) (
  input  logic              i_EMU_MCLK,
  input  logic              i_EMU_MRST_n,
  input  logic              i_EMU_CLK6MPCEN_n,
  input  logic              i_HFLIP,
  input  logic              i_VFLIP,
  input  logic [HS_W-1:0]   i_HCNT,
  input  logic [VS_W-1:0]   i_VCNT,
  input  logic              i_VCLK,
  input  logic [VA_W-1:0]   i_CPU_ADDR,
  input  logic [7:0]        i_GFXDATA,
  input  logic              i_GFXDATA_VALID,
  output logic [VA_W-1:0]   o_VRAMADDR,
  output logic [2:0]        o_TILELINEADDR,
  output logic [LAYERS-1:0] o_SHIFT_n,
  output logic [FL_W-1:0]   o_FETCH_LAYER,
  output logic              o_FETCH_VALID,
  output logic              o_LOAD_BUSY
);

  localparam int         LB       = layer_bits(LAYERS);
  localparam int         WIN      = win_size(LAYERS);
  localparam logic [2:0] WIN_MASK = 3'(WIN - 1);
  localparam logic [2:0] HALF     = 3'(WIN / 2);
  localparam int         CW       = HS_W - 3;

  logic            ce;
  logic [2:0]      phase, phase_f, slot;
  logic [CW-1:0]   hcnt_hi;
  logic [VS_W-1:0] vcnt_f;
  logic            fetch_half, fetch_start;
  logic [FL_W-1:0] slot_layer;

  assign ce          = ~i_EMU_CLK6MPCEN_n;
  assign phase       = i_HCNT[2:0];
  assign phase_f     = phase ^ {3{i_HFLIP}};
  assign hcnt_hi     = i_HCNT[HS_W-1:3] ^ {CW{i_HFLIP}};
  assign vcnt_f      = i_VCNT ^ {VS_W{i_VFLIP}};
  assign slot        = phase & WIN_MASK;
  assign fetch_half  = (slot >= HALF);
  assign fetch_start = (slot == HALF);
  assign slot_layer  = FL_W'(phase >> (3 - LB));

  load_state_e     state_q, state_d;
  logic [FL_W-1:0] layer_q, layer_d;
  logic            vhi_q, vhi_d;
  logic            vclk_q, vclk_rise;
  logic            wr_hlo, wr_hhi, wr_vlo, wr_vhi, commit, discard;

  assign vclk_rise = i_VCLK & ~vclk_q;

  // A line strobe always wins: it starts a load from IDLE or aborts one in flight.
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    vhi_d   = vhi_q;
    wr_hlo  = 1'b0;
    wr_hhi  = 1'b0;
    wr_vlo  = 1'b0;
    wr_vhi  = 1'b0;
    commit  = 1'b0;
    discard = 1'b0;
    if (ce) begin
      if (vclk_rise) begin
        state_d = LD_HLO;
        layer_d = '0;
        vhi_d   = 1'b0;
        discard = (state_q != LD_IDLE);
      end else begin
        case (state_q)
          LD_HLO: if (i_GFXDATA_VALID) begin
            wr_hlo  = 1'b1;
            state_d = LD_HHI;
          end
          LD_HHI: if (i_GFXDATA_VALID) begin
            wr_hhi  = 1'b1;
            state_d = LD_VS;
          end
          LD_VS: if (i_GFXDATA_VALID) begin
            wr_vlo = ~vhi_q;
            wr_vhi = vhi_q;
            if (VS_W > 8 && !vhi_q) begin
              vhi_d = 1'b1;
            end else begin
              vhi_d = 1'b0;
              if (layer_q == FL_W'(LAYERS - 1)) begin
                state_d = LD_WAIT_COMMIT;
              end else begin
                layer_d = layer_q + FL_W'(1);
                state_d = LD_HLO;
              end
            end
          end
          LD_WAIT_COMMIT: if (phase == 3'd7) begin
            commit  = 1'b1;
            state_d = LD_IDLE;
          end
          default: state_d = LD_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
    if (!i_EMU_MRST_n) begin
      state_q <= LD_IDLE;
      layer_q <= '0;
      vhi_q   <= 1'b0;
      vclk_q  <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      layer_q <= layer_d;
      vhi_q   <= vhi_d;
      vclk_q  <= i_VCLK;
    end
  end

  logic [HS_W-1:0] hs_act     [LAYERS];
  logic [VS_W-1:0] vs_act     [LAYERS];
  logic [VA_W-1:0] fetch_addr [LAYERS];
  logic [2:0]      line_addr  [LAYERS];

  for (genvar gi = 0; gi < LAYERS; gi++) begin : g_layer
    logic            sel;
    logic [VS_W-1:0] vsum;
    logic [CW-1:0]   col;
    logic [2:0]      shift_ph;

    assign sel = (layer_q == FL_W'(gi));

    tilemap_scroll_regs #(.HS_W(HS_W), .VS_W(VS_W)) u_regs (
      .clk_i     (i_EMU_MCLK),
      .rst_ni    (i_EMU_MRST_n),
      .wr_hlo_i  (wr_hlo & sel),
      .wr_hhi_i  (wr_hhi & sel),
      .wr_vlo_i  (wr_vlo & sel),
      .wr_vhi_i  (wr_vhi & sel),
      .data_i    (i_GFXDATA),
      .commit_i  (commit),
      .discard_i (discard),
      .hs_o      (hs_act[gi]),
      .vs_o      (vs_act[gi])
    );

    assign vsum           = vs_act[gi] + vcnt_f;
    assign col            = hs_act[gi][HS_W-1:3] + hcnt_hi;
    assign line_addr[gi]  = vsum[2:0];
    assign shift_ph       = hs_act[gi][2:0] + phase_f;
    assign o_SHIFT_n[gi]  = (shift_ph != 3'd7);

    if (LB == 0) begin : g_flat
      assign fetch_addr[gi] = {vsum[VS_W-1:3], col};
    end else begin : g_idx
      assign fetch_addr[gi] = {LB'(gi), vsum[VS_W-1:3], col};
    end
  end

  logic [2:0] tileline_q;

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
    if (!i_EMU_MRST_n) begin
      tileline_q <= '0;
    end else if (ce && fetch_start) begin
      tileline_q <= line_addr[slot_layer];
    end
  end

  assign o_VRAMADDR     = fetch_half ? fetch_addr[slot_layer] : i_CPU_ADDR;
  assign o_TILELINEADDR = tileline_q;
  assign o_FETCH_LAYER  = slot_layer;
  assign o_FETCH_VALID  = fetch_half;
  assign o_LOAD_BUSY    = (state_q != LD_IDLE);

endmodule

// File: tb/tb_tilemap_scroll_gen.sv
// Directed bench for tilemap_scroll_gen: slot mux, scroll arithmetic, flips,
// and the byte-stream loader (stall, abort, atomic commit), LAYERS=2 and 4.
module tb_tilemap_scroll_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cen_n, hflip, vflip, vclk, vclk4, gvalid;
  logic [8:0]  hcnt;
  logic [7:0]  vcnt, gdata;
  logic [11:0] cpu;
  logic [12:0] cpu4;

  logic [11:0] vaddr;
  logic [2:0]  tl;
  logic [1:0]  shn;
  logic        fl, fv, busy;
  logic [12:0] vaddr4;
  logic [2:0]  tl4;
  logic [3:0]  shn4;
  logic [1:0]  fl4;
  logic        fv4, busy4;

  int n_checks = 0;
  int n_fail   = 0;

  tilemap_scroll_gen #(.LAYERS(2), .HS_W(9), .VS_W(8)) dut (
    .i_EMU_MCLK(clk), .i_EMU_MRST_n(rst_n), .i_EMU_CLK6MPCEN_n(cen_n),
    .i_HFLIP(hflip), .i_VFLIP(vflip), .i_HCNT(hcnt), .i_VCNT(vcnt),
    .i_VCLK(vclk), .i_CPU_ADDR(cpu), .i_GFXDATA(gdata), .i_GFXDATA_VALID(gvalid),
    .o_VRAMADDR(vaddr), .o_TILELINEADDR(tl), .o_SHIFT_n(shn),
    .o_FETCH_LAYER(fl), .o_FETCH_VALID(fv), .o_LOAD_BUSY(busy)
  );

  tilemap_scroll_gen #(.LAYERS(4), .HS_W(9), .VS_W(8)) dut4 (
    .i_EMU_MCLK(clk), .i_EMU_MRST_n(rst_n), .i_EMU_CLK6MPCEN_n(cen_n),
    .i_HFLIP(hflip), .i_VFLIP(vflip), .i_HCNT(hcnt), .i_VCNT(vcnt),
    .i_VCLK(vclk4), .i_CPU_ADDR(cpu4), .i_GFXDATA(gdata), .i_GFXDATA_VALID(gvalid),
    .o_VRAMADDR(vaddr4), .o_TILELINEADDR(tl4), .o_SHIFT_n(shn4),
    .o_FETCH_LAYER(fl4), .o_FETCH_VALID(fv4), .o_LOAD_BUSY(busy4)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Inputs change on the falling edge; combinational outputs are sampled 1ns later.
  task automatic probe(input string tag, input logic [8:0] h, input logic [11:0] exp);
    @(negedge clk);
    hcnt = h;
    #1;
    check_val(tag, 32'(vaddr), 32'(exp));
  endtask

  task automatic start_load();
    vclk = 1'b1;
    step();
    vclk = 1'b0;
    check_val("load_start_busy", 32'(busy), 32'd1);
  endtask

  task automatic feed(input logic [47:0] bytes, input int n, input int stall_before,
                      input int stall_len);
    for (int i = 0; i < n; i++) begin
      if (i == stall_before) begin
        for (int s = 0; s < stall_len; s++) begin
          gvalid = 1'b0;
          gdata  = 8'hEE;
          step();
          check_val("stall_busy", 32'(busy), 32'd1);
        end
      end
      gvalid = 1'b1;
      gdata  = bytes[47-8*i -: 8];
      step();
    end
    gvalid = 1'b0;
  endtask

  task automatic commit_load(input logic [47:0] bytes);
    hcnt = 9'd3;
    step();
    check_val("precommit_busy", 32'(busy), 32'd1);
    hcnt = 9'd7;
    step();
    check_val("commit_idle", 32'(busy), 32'd0);
    hcnt = 9'd0;
    $display("load committed: bytes %012h", bytes);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cen_n = 1'b0; hflip = 1'b0; vflip = 1'b0;
    hcnt = '0; vcnt = '0; vclk = 1'b0; vclk4 = 1'b0;
    cpu = 12'hABC; cpu4 = 13'h1234; gdata = '0; gvalid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_tl", 32'(tl), 32'd0);
    check_val("rst_cpu_addr", 32'(vaddr), 32'hABC);
    check_val("rst_fv", 32'(fv), 32'd0);
    check_val("rst_shift_p0", 32'(shn), 32'b00);
    check_val("rst_busy4", 32'(busy4), 32'd0);
    check_val("rst_shift4_p0", 32'(shn4), 32'b0000);
    probe("rst_fetch_l0", 9'd2, 12'h043);
    check_val("rst_tl_held", 32'(tl), 32'd0);
    rst_n = 1'b1;
    hcnt = 9'd0;
    step();

    for (int p = 0; p < 8; p++) begin
      @(negedge clk);
      hcnt = 9'(p);
      #1;
      check_val("l4_layer", 32'(fl4), 32'(p / 2));
      if (p % 2 == 1) begin
        check_val("l4_fv", 32'(fv4), 32'd1);
        check_val("l4_fetch", 32'(vaddr4), 32'((p / 2) * 13'h800 + 13'h043));
      end else begin
        check_val("l4_fv", 32'(fv4), 32'd0);
        check_val("l4_cpu", 32'(vaddr4), 32'(cpu4));
      end
    end
    step();
    check_val("l4_tileline", 32'(tl4), 32'd7);

    probe("fetch_l0", 9'd2, 12'h043);
    check_val("fetch_l0_fv", 32'(fv), 32'd1);
    check_val("fetch_l0_layer", 32'(fl), 32'd0);
    check_val("fetch_l0_shift", 32'(shn), 32'b11);
    step();
    check_val("line_l0", 32'(tl), 32'd7);
    probe("fetch_l1", 9'd6, 12'h843);
    check_val("fetch_l1_layer", 32'(fl), 32'd1);
    probe("cpu_p5", 9'd5, 12'hABC);
    check_val("cpu_p5_fv", 32'(fv), 32'd0);

    hflip = 1'b1;
    probe("hflip_col", 9'd2, 12'h042);
    check_val("hflip_shift_p2", 32'(shn), 32'b11);
    probe("hflip_l1", 9'd7, 12'h842);
    check_val("hflip_shift_p7", 32'(shn), 32'b00);
    hflip = 1'b0;

    vflip = 1'b1;
    probe("vflip_addr", 9'd2, 12'h043);
    step();
    check_val("vflip_line", 32'(tl), 32'd6);
    vflip = 1'b0;

    @(negedge clk);
    cen_n = 1'b1;
    vclk  = 1'b1;
    hcnt  = 9'd2;
    step();
    step();
    check_val("ce_gate_busy", 32'(busy), 32'd0);
    check_val("ce_gate_line", 32'(tl), 32'd6);
    @(negedge clk);
    vclk  = 1'b0;
    cen_n = 1'b0;
    hcnt  = 9'd0;
    step();

    start_load();
    feed(48'h10_01_20_00_00_00, 6, -1, 0);
    probe("old_l0", 9'd2, 12'h043);
    probe("old_l1", 9'd6, 12'h843);
    check_val("wait_busy", 32'(busy), 32'd1);
    commit_load(48'h10_01_20_00_00_00);
    probe("new_l0", 9'd2, 12'h122);
    probe("new_l1", 9'd6, 12'h800);
    probe("new_p7", 9'd7, 12'h800);
    check_val("new_shift_p7", 32'(shn), 32'b00);
    probe("new_p0", 9'd0, 12'hABC);
    check_val("new_shift_p0", 32'(shn), 32'b11);

    hcnt = 9'd0;
    start_load();
    feed(48'h10_01_20_08_00_18, 6, 1, 5);
    commit_load(48'h10_01_20_08_00_18);
    probe("stall_l0", 9'd2, 12'h122);
    probe("stall_l1", 9'd6, 12'h8C1);

    hcnt = 9'd0;
    start_load();
    feed(48'h55_01_33_66_00_00, 5, -1, 0);
    gvalid = 1'b1;
    gdata  = 8'h77;
    vclk   = 1'b1;
    step();
    vclk   = 1'b0;
    gvalid = 1'b0;
    check_val("abort_busy", 32'(busy), 32'd1);
    probe("abort_keep_l0", 9'd2, 12'h122);
    probe("abort_keep_l1", 9'd6, 12'h8C1);
    hcnt = 9'd0;
    feed(48'h00_00_08_00_00_00, 6, -1, 0);
    commit_load(48'h00_00_08_00_00_00);
    probe("restart_l0", 9'd2, 12'h040);
    probe("restart_l1", 9'd6, 12'h800);

    hcnt = 9'd0;
    start_load();
    feed(48'hFF_01_0F_00_00_00, 6, -1, 0);
    commit_load(48'hFF_01_0F_00_00_00);
    probe("col_wrap", 9'h1FA, 12'h07E);
    vflip = 1'b1;
    probe("col_wrap_vflip", 9'h1FA, 12'h07E);
    step();
    check_val("vflip_line_wrap", 32'(tl), 32'd6);
    vflip = 1'b0;
    check_val("end_busy4", 32'(busy4), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
